// File: rtl/mult_param_seq.sv
// Sequential digit-serial unsigned multiplier: consumes DIGIT bits of b per cycle.
// Optional early termination after the highest non-zero digit of b: MULT_EARLY_TERM_EN.
module mult_param_seq #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int D  = WIDTH / DIGIT;
    localparam int CW = (D > 1) ? $clog2(D) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CALC = 1'b1;

    localparam logic [CW-1:0] LAST_DIGIT = CW'(D - 1);

    logic [0:0]         state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;

    logic [DIGIT-1:0]   digit;
    logic [2*WIDTH-1:0] term;
    logic [2*WIDTH-1:0] acc_sum;
    logic [CW-1:0]      last_idx;
    logic [CW-1:0]      start_last;

`ifdef MULT_EARLY_TERM_EN
    logic [CW-1:0] last_q, last_d;

    // Index of the highest non-zero digit of the incoming b (0 when b is zero).
    always_comb begin
        start_last = '0;
        for (int i = 0; i < D; i++) begin
            if (b[i*DIGIT +: DIGIT] != '0) start_last = CW'(i);
        end
    end

    assign last_idx = last_q;
`else
    assign start_last = LAST_DIGIT;
    assign last_idx   = LAST_DIGIT;
`endif

    // Partial product of the current digit, aligned to its weight in the accumulator.
    assign digit   = DIGIT'(b_q >> (DIGIT * int'(cnt_q)));
    assign term    = ((2*WIDTH)'(a_q) * (2*WIDTH)'(digit)) << (DIGIT * int'(cnt_q));
    assign acc_sum = acc_q + term;

    // NOTE: every variable assigned here gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        prod_d  = prod_q;
`ifdef MULT_EARLY_TERM_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CALC;
`ifdef MULT_EARLY_TERM_EN
                    last_d  = start_last;
`endif
                end
            end
            CALC: begin
                acc_d = acc_sum;
                if (cnt_q == last_idx) begin
                    prod_d  = acc_sum;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            prod_q  <= prod_d;
        end
    end

`ifdef MULT_EARLY_TERM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) last_q <= '0;
        else       last_q <= last_d;
    end
`else
    logic unused_start_last;
    assign unused_start_last = ^start_last;
`endif

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = prod_q;

endmodule

// File: tb/tb_mult_param_seq.sv
// Self-checking bench for mult_param_seq: directed cases plus randomized operands
// against an arithmetic reference model; honours MULT_EARLY_TERM_EN for busy length.
module tb_mult_param_seq;

    localparam int WIDTH = 32;
    localparam int DIGIT = 8;
    localparam int D     = WIDTH / DIGIT;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    int n_cmp = 0;
    int n_err = 0;
    logic [2*WIDTH-1:0] last_prod;

    mult_param_seq #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: exact unsigned product.
    function automatic logic [63:0] model_prod(input logic [31:0] av, input logic [31:0] bv);
        logic [63:0] x = {32'd0, av};
        logic [63:0] y = {32'd0, bv};
        return x * y;
    endfunction

    // Reference: number of busy cycles for a given multiplier.
    function automatic int model_cycles(input logic [31:0] bv);
`ifdef MULT_EARLY_TERM_EN
        int n = 1;
        logic [31:0] v = bv >> DIGIT;
        while (v != 0) begin
            n++;
            v = v >> DIGIT;
        end
        return n;
`else
        return D;
`endif
    endfunction

    // Called at a negedge; returns at the negedge after the start-sampling edge.
    task automatic launch(input logic [31:0] av, input logic [31:0] bv);
        a = av;
        b = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Follows the operation to its done cycle; optionally disturbs inputs while busy.
    task automatic wait_result(input logic [63:0] exp_prod, input int exp_cycles,
                               input logic [63:0] prev, input bit disturb);
        int n = 0;
        while (busy === 1'b1 && n < 40) begin
            check("prod_hold", product, prev);
            check("done_low_busy", {63'd0, done}, 64'd0);
            if (disturb) begin
                a = $urandom;
                b = $urandom;
                start = 1'($urandom_range(0, 1));
            end
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_cycles", 64'(n), 64'(exp_cycles));
        check("done_pulse", {63'd0, done}, 64'd1);
        check("product", product, exp_prod);
    endtask

    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input bit disturb);
        logic [63:0] exp_p = model_prod(av, bv);
        launch(av, bv);
        wait_result(exp_p, model_cycles(bv), last_prod, disturb);
        last_prod = exp_p;
    endtask

    task automatic gap();
        @(negedge clk);
        check("done_single", {63'd0, done}, 64'd0);
        check("busy_idle", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        last_prod = '0;
        repeat (4) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_product", product, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op(32'h1340_4874, 32'h11E2_F516, 1'b0);
        gap();
        run_op(32'h0000_4874, 32'h0000_F516, 1'b0);
        gap();

        // Back-to-back: second start issued in the done cycle.
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("max_const", product, 64'hFFFF_FFFE_0000_0001);
        run_op(32'd5, 32'd0, 1'b0);
        gap();

        // Start pulses and operand changes while busy must be ignored.
        run_op(32'hDEAD_BEEF, 32'h0102_0304, 1'b1);
        gap();

        // Reset during the second CALC cycle.
        launch(32'h1234_5678, 32'h8765_4321);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_product", product, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        last_prod = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", {63'd0, done}, 64'd0);
        end
        run_op(32'd3, 32'd7, 1'b0);
        gap();

        for (int i = 0; i < 30; i++) begin
            logic [31:0] av = $urandom;
            logic [31:0] bv = $urandom;
            bv = bv >> (DIGIT * $urandom_range(0, D));
            run_op(av, bv, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) gap();
        end
        gap();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
